// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4 read arbiter:
// FSM state encoding, requester (owner) encoding and fixed AXI field values.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [2:0] ARSIZE_4B    = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Two-way grant selector: a lone requester always wins, and on a tie the
// side named by 'favour' wins. With nobody asking the result is don't-care.
module axi_rd_arbiter_rr_pick
    import axi_rd_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t favour,
    output owner_t pick
);

    // Choose the winner of the current request pattern
    always_comb begin
        pick = OWN_D;
        if (i_req && d_req) begin
            pick = favour;
        end else if (i_req) begin
            pick = OWN_I;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between an instruction-fetch requester (I)
// and a data-load requester (D), one single-beat transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between requesters;
// without it D always wins a tie and no pointer register is built.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32
)
(
    input  logic                               CLK,
    input  logic                               RST,

    input  logic                               I_REQ,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      I_ADDR,
    output logic                               I_GNT,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      I_RDATA,
    output logic                               I_RVALID,
    output logic                               I_RERR,

    input  logic                               D_REQ,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      D_ADDR,
    output logic                               D_GNT,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      D_RDATA,
    output logic                               D_RVALID,
    output logic                               D_RERR,

    output logic                               BUSY,

    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,

    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    state_t state;
    state_t state_next;
    owner_t owner;
    owner_t pick;
    owner_t favour;
    logic   any_req;
    logic   latch_req;
    logic   r_done;

    // Single-beat reads only: ID and RLAST carry no information here.
    logic unused_r_fields;
    assign unused_r_fields = ^{M_AXI_RID, M_AXI_RLAST};

    assign any_req   = I_REQ || D_REQ;
    assign latch_req = (state == IDLE) && any_req;
    assign r_done    = (state == RESP) && M_AXI_RVALID;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = ARSIZE_4B;
    assign M_AXI_ARBURST = ARBURST_INCR;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t rr_ptr;

    // Hand the tie-break to the side that did not win the latest grant
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rr_ptr <= OWN_D;
        end else if (latch_req) begin
            rr_ptr <= other_owner(pick);
        end
    end

    assign favour = rr_ptr;
`else
    assign favour = OWN_D;
`endif

    axi_rd_arbiter_rr_pick rr_pick (
        .i_req  (I_REQ),
        .d_req  (D_REQ),
        .favour (favour),
        .pick   (pick)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the handshake-facing outputs, all decoded from state
    always_comb begin
        state_next    = state;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        I_GNT         = 1'b0;
        D_GNT         = 1'b0;
        BUSY          = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                M_AXI_ARVALID = 1'b1;
                BUSY          = 1'b1;
                if (M_AXI_ARREADY) begin
                    state_next = RESP;
                    I_GNT      = (owner == OWN_I);
                    D_GNT      = (owner == OWN_D);
                end
            end
            RESP: begin
                M_AXI_RREADY = 1'b1;
                BUSY         = 1'b1;
                if (M_AXI_RVALID) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winner and its address when leaving IDLE; both stay put
    // until the next arbitration so ARADDR is stable through backpressure
    always_ff @(posedge CLK) begin
        if (!RST) begin
            owner        <= OWN_D;
            M_AXI_ARADDR <= '0;
        end else if (latch_req) begin
            owner        <= pick;
            M_AXI_ARADDR <= (pick == OWN_D) ? D_ADDR : I_ADDR;
        end
    end

    // Route the accepted R beat to its owner: data is held, valid/error pulse
    always_ff @(posedge CLK) begin
        if (!RST) begin
            I_RDATA  <= '0;
            I_RVALID <= 1'b0;
            I_RERR   <= 1'b0;
            D_RDATA  <= '0;
            D_RVALID <= 1'b0;
            D_RERR   <= 1'b0;
        end else begin
            I_RVALID <= 1'b0;
            I_RERR   <= 1'b0;
            D_RVALID <= 1'b0;
            D_RERR   <= 1'b0;
            if (r_done) begin
                if (owner == OWN_I) begin
                    I_RDATA  <= M_AXI_RDATA;
                    I_RVALID <= 1'b1;
                    I_RERR   <= (M_AXI_RRESP != RESP_OKAY);
                end else begin
                    D_RDATA  <= M_AXI_RDATA;
                    D_RVALID <= 1'b1;
                    D_RERR   <= (M_AXI_RRESP != RESP_OKAY);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with a transaction-level reference model.
// Honours ARB_ROUND_ROBIN_EN for the tie-break expectations.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr;
    logic        i_gnt, d_gnt;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rvalid, d_rvalid, i_rerr, d_rerr;
    logic        busy;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [0:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int total_checks = 0;
    int bad_checks   = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .C_M_AXI_THREAD_ID_WIDTH (1),
        .C_M_AXI_ADDR_WIDTH      (32),
        .C_M_AXI_DATA_WIDTH      (32)
    ) dut (
        .CLK           (clk),
        .RST           (rst_n),
        .I_REQ         (i_req),
        .I_ADDR        (i_addr),
        .I_GNT         (i_gnt),
        .I_RDATA       (i_rdata),
        .I_RVALID      (i_rvalid),
        .I_RERR        (i_rerr),
        .D_REQ         (d_req),
        .D_ADDR        (d_addr),
        .D_GNT         (d_gnt),
        .D_RDATA       (d_rdata),
        .D_RVALID      (d_rvalid),
        .D_RERR        (d_rerr),
        .BUSY          (busy),
        .M_AXI_ARID    (arid),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARLEN   (arlen),
        .M_AXI_ARSIZE  (arsize),
        .M_AXI_ARBURST (arburst),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RID     (rid),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RLAST   (rlast),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                                 input logic ard, input logic rv, input logic [31:0] rd, input logic [1:0] rr);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_addr  = da;
        arready = ard;
        rvalid  = rv;
        rdata   = rd;
        rresp   = rr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: one read in flight, tracked as "free / address pending /
    // data pending"; requester 0 is I, 1 is D.
    int          m_slot;
    int          m_owner;
    int          m_last;
    logic [31:0] m_addr;
    logic [31:0] m_rdata [2];
    logic        m_rvalid [2];
    logic        m_rerr [2];
    bit          m_live = 0;

    function automatic int chooseOwner(input logic iq, input logic dq, input int last);
        if (iq && dq) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (last == 1) ? 0 : 1;
`else
            return (last >= 0) ? 1 : 1;
`endif
        end
        return dq ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_slot      <= 0;
            m_owner     <= 0;
            m_last      <= 0;
            m_addr      <= '0;
            m_rdata[0]  <= '0;
            m_rdata[1]  <= '0;
            m_rvalid[0] <= 1'b0;
            m_rvalid[1] <= 1'b0;
            m_rerr[0]   <= 1'b0;
            m_rerr[1]   <= 1'b0;
            m_live      <= 1'b1;
        end else begin
            m_rvalid[0] <= 1'b0;
            m_rvalid[1] <= 1'b0;
            m_rerr[0]   <= 1'b0;
            m_rerr[1]   <= 1'b0;
            if (m_slot == 2 && rvalid) begin
                m_rdata[m_owner]  <= rdata;
                m_rvalid[m_owner] <= 1'b1;
                m_rerr[m_owner]   <= (rresp != 2'b00);
                m_slot            <= 0;
            end else if (m_slot == 1 && arready) begin
                m_slot <= 2;
            end else if (m_slot == 0 && (i_req || d_req)) begin
                m_owner <= chooseOwner(i_req, d_req, m_last);
                m_last  <= chooseOwner(i_req, d_req, m_last);
                m_addr  <= (chooseOwner(i_req, d_req, m_last) == 1) ? d_addr : i_addr;
                m_slot  <= 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("arvalid",  {31'b0, arvalid},  {31'b0, m_slot == 1});
            checkOutput("araddr",   araddr,            m_addr);
            checkOutput("i_gnt",    {31'b0, i_gnt},    {31'b0, m_slot == 1 && arready && m_owner == 0});
            checkOutput("d_gnt",    {31'b0, d_gnt},    {31'b0, m_slot == 1 && arready && m_owner == 1});
            checkOutput("rready",   {31'b0, rready},   {31'b0, m_slot == 2});
            checkOutput("busy",     {31'b0, busy},     {31'b0, m_slot != 0});
            checkOutput("i_rvalid", {31'b0, i_rvalid}, {31'b0, m_rvalid[0]});
            checkOutput("i_rerr",   {31'b0, i_rerr},   {31'b0, m_rerr[0]});
            checkOutput("i_rdata",  i_rdata,           m_rdata[0]);
            checkOutput("d_rvalid", {31'b0, d_rvalid}, {31'b0, m_rvalid[1]});
            checkOutput("d_rerr",   {31'b0, d_rerr},   {31'b0, m_rerr[1]});
            checkOutput("d_rdata",  d_rdata,           m_rdata[1]);
            checkOutput("ar_const", {19'b0, arid, arlen, arsize, arburst}, 32'h0000_0009);
        end
    end

    // Logs of grants and responses plus a windowed cycle counter
    logic [32:0] gnt_log [$];
    logic [33:0] resp_log [$];
    bit count_en = 0;
    int arv_cnt, gnt_cnt, gnt_at, rr_cnt;

    always @(negedge clk) begin
        if (i_gnt) gnt_log.push_back({1'b0, araddr});
        if (d_gnt) gnt_log.push_back({1'b1, araddr});
        if (i_rvalid) resp_log.push_back({1'b0, i_rerr, i_rdata});
        if (d_rvalid) resp_log.push_back({1'b1, d_rerr, d_rdata});
        if (!count_en) begin
            arv_cnt = 0;
            gnt_cnt = 0;
            gnt_at  = 0;
            rr_cnt  = 0;
        end else begin
            if (arvalid) arv_cnt++;
            if (i_gnt || d_gnt) begin
                gnt_cnt++;
                gnt_at = arv_cnt;
            end
            if (rready) rr_cnt++;
        end
    end

    function automatic logic [32:0] gntAt(input int idx);
        if (idx < gnt_log.size()) return gnt_log[idx];
        return '1;
    endfunction

    function automatic logic [33:0] respAt(input int idx);
        if (idx < resp_log.size()) return resp_log[idx];
        return '1;
    endfunction

    // Requesters drop REQ on the cycle after they see their grant
    task automatic runHeldRequesters(input int cycles, input bit drop_on_gnt);
        logic gi, gd;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            gi = i_gnt;
            gd = d_gnt;
            tick();
            if (drop_on_gnt && gi) i_req = 1'b0;
            if (drop_on_gnt && gd) d_req = 1'b0;
        end
    endtask

    initial begin
        int gb, rb;
        logic [32:0] ge;
        logic [33:0] re;
        int exp_own [4];

        rst_n = 1'b0;
        rid   = '0;
        rlast = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("reset_busy",    {31'b0, busy},    32'd0);
        checkOutput("reset_arvalid", {31'b0, arvalid}, 32'd0);
        checkOutput("reset_araddr",  araddr,           32'd0);
        checkOutput("reset_i_rdata", i_rdata,          32'd0);

        $display("[TB] single fetch");
        gb = gnt_log.size();
        rb = resp_log.size();
        applyStimulus(1, 32'h0000_0100, 0, 0, 1, 0, 0, 0);
        tick();
        tick();
        applyStimulus(0, 32'h0000_0100, 0, 0, 0, 1, 32'h0000_0013, 2'b00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s1_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        checkOutput("s1_i_rdata",  i_rdata,           32'h0000_0013);
        checkOutput("s1_i_rerr",   {31'b0, i_rerr},   32'd0);
        checkOutput("s1_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        tick();
        checkOutput("s1_gnt_count", gnt_log.size() - gb, 32'd1);
        ge = gntAt(gb);
        checkOutput("s1_gnt_owner", {31'b0, ge[32]}, 32'd0);
        checkOutput("s1_gnt_addr",  ge[31:0],        32'h0000_0100);
        checkOutput("s1_resp_count", resp_log.size() - rb, 32'd1);

        $display("[TB] tie, D then I");
        gb = gnt_log.size();
        rb = resp_log.size();
        applyStimulus(1, 32'h0000_0200, 1, 32'h8000_0000, 1, 1, 32'h0000_00AA, 2'b00);
        runHeldRequesters(12, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("s2_gnt_count", gnt_log.size() - gb, 32'd2);
        ge = gntAt(gb);
        checkOutput("s2_first_owner", {31'b0, ge[32]}, 32'd1);
        checkOutput("s2_first_addr",  ge[31:0],        32'h8000_0000);
        ge = gntAt(gb + 1);
        checkOutput("s2_second_owner", {31'b0, ge[32]}, 32'd0);
        checkOutput("s2_second_addr",  ge[31:0],        32'h0000_0200);
        checkOutput("s2_resp_count", resp_log.size() - rb, 32'd2);

        $display("[TB] tie held for four transactions");
`ifdef ARB_ROUND_ROBIN_EN
        exp_own = '{1, 0, 1, 0};
`else
        exp_own = '{1, 1, 1, 1};
`endif
        gb = gnt_log.size();
        applyStimulus(1, 32'h0000_0600, 1, 32'h0000_0700, 1, 1, 32'h0000_0011, 2'b00);
        runHeldRequesters(12, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("s3_gnt_count", gnt_log.size() - gb, 32'd4);
        for (int k = 0; k < 4; k++) begin
            ge = gntAt(gb + k);
            checkOutput($sformatf("s3_owner%0d", k), {31'b0, ge[32]}, exp_own[k]);
            checkOutput($sformatf("s3_addr%0d", k), ge[31:0], (exp_own[k] == 1) ? 32'h0000_0700 : 32'h0000_0600);
        end

        $display("[TB] backpressure");
        rb = resp_log.size();
        applyStimulus(0, 0, 1, 32'h4000_0010, 0, 0, 0, 0);
        count_en = 1;
        tick();
        repeat (5) tick();
        applyStimulus(0, 0, 1, 32'h4000_0010, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h1234_5678, 2'b00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("s4_arvalid_cycles", arv_cnt, 32'd6);
        checkOutput("s4_gnt_cycles",     gnt_cnt, 32'd1);
        checkOutput("s4_gnt_cycle_no",   gnt_at,  32'd6);
        checkOutput("s4_rready_cycles",  rr_cnt,  32'd4);
        count_en = 0;
        re = respAt(rb);
        checkOutput("s4_resp_owner", {31'b0, re[33]}, 32'd1);
        checkOutput("s4_resp_data",  re[31:0],        32'h1234_5678);

        $display("[TB] error response");
        applyStimulus(1, 32'h0000_0300, 0, 0, 1, 0, 0, 0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 2'b10);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s5_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        checkOutput("s5_i_rerr",   {31'b0, i_rerr},   32'd1);
        checkOutput("s5_i_rdata",  i_rdata,           32'hDEAD_BEEF);
        checkOutput("s5_d_rdata_held", d_rdata,       32'h1234_5678);
        tick();

        $display("[TB] reset during response");
        rb = resp_log.size();
        applyStimulus(1, 32'h0000_0400, 0, 0, 1, 0, 0, 0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0077, 2'b00);
        rst_n = 1'b0;
        tick();
        checkOutput("s6_i_rvalid", {31'b0, i_rvalid}, 32'd0);
        checkOutput("s6_busy",     {31'b0, busy},     32'd0);
        checkOutput("s6_rready",   {31'b0, rready},   32'd0);
        checkOutput("s6_arvalid",  {31'b0, arvalid},  32'd0);
        checkOutput("s6_i_rdata",  i_rdata,           32'd0);
        checkOutput("s6_d_rdata",  d_rdata,           32'd0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 32'h0000_0500, 0, 0, 1, 0, 0, 0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0055, 2'b00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s6_fresh_rvalid", {31'b0, i_rvalid}, 32'd1);
        checkOutput("s6_fresh_rdata",  i_rdata,           32'h0000_0055);
        tick();
        tick();
        checkOutput("s6_resp_count", resp_log.size() - rb, 32'd1);
        re = respAt(rb);
        checkOutput("s6_resp_data", re[31:0], 32'h0000_0055);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
